// File: rtl/por_cfg_pkg.sv
// Shared definitions for the power-on configuration sequencer.
// Holds the FSM state encoding and the checksum fold used on the EEPROM image.
package por_cfg_pkg;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Fold capacity: callers zero-fill unused word slots and upper bits.
  localparam int unsigned XF_MAX_WORDS = 16;
  localparam int unsigned XF_MAX_DW    = 32;

  typedef logic [XF_MAX_DW-1:0]                    xf_word_t;
  typedef logic [XF_MAX_WORDS-1:0][XF_MAX_DW-1:0]  xf_vec_t;

  function automatic xf_word_t xor_fold(input xf_vec_t words);
    xf_word_t acc;
    acc = '0;
    for (int i = 0; i < XF_MAX_WORDS; i++) begin
      acc = acc ^ words[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/por_cfg_ctrl_if.sv
// EEPROM read port between the configuration sequencer (master) and the EEPROM (slave).
interface por_cfg_ctrl_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          ee_wbusy_comb;
  logic          ee_rd_req;
  logic [AW-1:0] ee_rd_addr;
  logic          ee_rd_ack;
  logic [DW-1:0] ee_rd_data;

  modport master (
    output ee_rd_req, ee_rd_addr,
    input  ee_wbusy_comb, ee_rd_ack, ee_rd_data
  );

  modport slave (
    input  ee_rd_req, ee_rd_addr,
    output ee_wbusy_comb, ee_rd_ack, ee_rd_data
  );
endinterface

// File: rtl/por_cfg_rd_if.sv
// Request/acknowledge engine for one EEPROM word: wbusy gating on launch and
// ack timeout while the request is outstanding.
module por_cfg_rd_if #(
  parameter int unsigned ACK_TO = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wbusy,
  input  logic ack,
  output logic req,
  output logic done_c,
  output logic timeout_c
);

  localparam int unsigned TW = $clog2(ACK_TO + 1);

  logic [TW-1:0] to_cnt;

  // An ack in the expiry cycle still counts as a completed read.
  assign done_c    = req & ack;
  assign timeout_c = req & ~ack & (to_cnt == TW'(ACK_TO - 1));

  // Launch only while the EEPROM is not writing; once launched, wbusy is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req    <= 1'b0;
      to_cnt <= '0;
    end else if (done_c || timeout_c) begin
      req    <= 1'b0;
      to_cnt <= '0;
    end else if (req) begin
      to_cnt <= to_cnt + 1'b1;
    end else if (en && !wbusy) begin
      req    <= 1'b1;
    end
  end

endmodule

// File: rtl/por_cfg_ctrl.sv
// Power-on configuration sequencer: settles, reads config words plus checksum from
// EEPROM, retries on failure, and publishes the image with done flags.
module por_cfg_ctrl
  import por_cfg_pkg::*;
#(
  parameter int unsigned CFG_WORDS  = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 4,
  parameter int unsigned CFG_BASE   = 0,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned ACK_TO     = 64,
  parameter int unsigned MAX_RETRY  = 2,
  parameter logic [CFG_WORDS*DW-1:0] CFG_DEFAULT = '0
) (
  input  logic                    timer_clk,
  input  logic                    por_rst_n,
  input  logic                    cfg_reload,
  por_cfg_ctrl_if.master          ee,
  output logic [CFG_WORDS*DW-1:0] cfg_data,
  output logic                    por_cfg_done,
  output logic                    por_cfg_done_r,
  output logic                    cfg_err
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned IW = $clog2(CFG_WORDS + 2);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  logic [1:0]    state_q, state_nxt;
  logic [SW-1:0] settle_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] stage_q [CFG_WORDS];
  logic [DW-1:0] chk_q;
  logic          att_fail_q;
  logic [RW-1:0] retry_q;

  logic    rd_req, rd_done_c, rd_timeout_c, req_en_c;
  logic    last_word_c, pass_c;
  xf_vec_t fold_in;

  assign req_en_c       = (state_q == ST_REQ);
  assign last_word_c    = (idx_q == IW'(CFG_WORDS));
  assign ee.ee_rd_req   = rd_req;
  assign ee.ee_rd_addr  = addr_q;

  por_cfg_rd_if #(.ACK_TO(ACK_TO)) u_rd (
    .clk       (timer_clk),
    .rst_n     (por_rst_n),
    .en        (req_en_c),
    .wbusy     (ee.ee_wbusy_comb),
    .ack       (ee.ee_rd_ack),
    .req       (rd_req),
    .done_c    (rd_done_c),
    .timeout_c (rd_timeout_c)
  );

  // Checksum verdict on the staged image; a timed-out attempt never passes.
  always_comb begin
    fold_in = '0;
    for (int i = 0; i < CFG_WORDS; i++) begin
      fold_in[i] = XF_MAX_DW'(stage_q[i]);
    end
  end

  assign pass_c = !att_fail_q && (DW'(xor_fold(fold_in)) == chk_q);

  always_ff @(posedge timer_clk or negedge por_rst_n) begin
    if (!por_rst_n) state_q <= ST_SETTLE;
    else            state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_SETTLE: if (settle_q == SW'(SETTLE_CYC - 1)) state_nxt = ST_REQ;
      ST_REQ:    if (rd_timeout_c || (rd_done_c && last_word_c)) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = (pass_c || retry_q == RW'(MAX_RETRY)) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (cfg_reload) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_SETTLE;
    endcase
  end

  // Datapath: published outputs only change in CHECK (and done on reload).
  always_ff @(posedge timer_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      settle_q       <= '0;
      idx_q          <= '0;
      addr_q         <= AW'(CFG_BASE);
      for (int i = 0; i < CFG_WORDS; i++) stage_q[i] <= '0;
      chk_q          <= '0;
      att_fail_q     <= 1'b0;
      retry_q        <= '0;
      cfg_data       <= CFG_DEFAULT;
      por_cfg_done   <= 1'b0;
      por_cfg_done_r <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      por_cfg_done_r <= por_cfg_done;
      settle_q <= (state_q == ST_SETTLE && state_nxt == ST_SETTLE) ? settle_q + 1'b1 : '0;
      case (state_q)
        ST_SETTLE: begin
          if (state_nxt == ST_REQ) begin
            idx_q      <= '0;
            addr_q     <= AW'(CFG_BASE);
            att_fail_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (rd_done_c) begin
            for (int i = 0; i < CFG_WORDS; i++) begin
              if (idx_q == IW'(i)) stage_q[i] <= ee.ee_rd_data;
            end
            if (last_word_c) chk_q <= ee.ee_rd_data;
            idx_q  <= idx_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
          if (rd_timeout_c) att_fail_q <= 1'b1;
        end
        ST_CHECK: begin
          if (pass_c) begin
            for (int i = 0; i < CFG_WORDS; i++) cfg_data[i*DW +: DW] <= stage_q[i];
            cfg_err      <= 1'b0;
            por_cfg_done <= 1'b1;
          end else if (retry_q == RW'(MAX_RETRY)) begin
            cfg_data     <= CFG_DEFAULT;
            cfg_err      <= 1'b1;
            por_cfg_done <= 1'b1;
          end else begin
            retry_q      <= retry_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (cfg_reload) begin
            por_cfg_done <= 1'b0;
            retry_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_por_cfg_ctrl.sv
// Self-checking bench for por_cfg_ctrl: EEPROM responder model plus a cycle-count
// and image reference computed from the sequencing rules.
module tb_por_cfg_ctrl;

  localparam int unsigned CFG_WORDS  = 4;
  localparam int unsigned DW         = 8;
  localparam int unsigned AW         = 4;
  localparam int unsigned CFG_BASE   = 0;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned ACK_TO     = 64;
  localparam int unsigned MAX_RETRY  = 2;
  localparam int unsigned CW         = CFG_WORDS * DW;
  localparam int unsigned CHK_ADDR   = CFG_BASE + CFG_WORDS;

  logic          timer_clk = 1'b0;
  logic          por_rst_n;
  logic          cfg_reload = 1'b0;
  logic [CW-1:0] cfg_data;
  logic          por_cfg_done, por_cfg_done_r, cfg_err;

  por_cfg_ctrl_if #(.AW(AW), .DW(DW)) ee ();

  por_cfg_ctrl #(
    .CFG_WORDS(CFG_WORDS), .DW(DW), .AW(AW), .CFG_BASE(CFG_BASE),
    .SETTLE_CYC(SETTLE_CYC), .ACK_TO(ACK_TO), .MAX_RETRY(MAX_RETRY), .CFG_DEFAULT('0)
  ) dut (
    .timer_clk      (timer_clk),
    .por_rst_n      (por_rst_n),
    .cfg_reload     (cfg_reload),
    .ee             (ee),
    .cfg_data       (cfg_data),
    .por_cfg_done   (por_cfg_done),
    .por_cfg_done_r (por_cfg_done_r),
    .cfg_err        (cfg_err)
  );

  always #5 timer_clk = ~timer_clk;

  // EEPROM responder: acks after ack_dly cycles of req; corrupts the first bad_n checksum reads.
  logic [DW-1:0] mem [16];
  int unsigned   ack_dly = 0, bad_n = 0, chk_base = 0, chk_reads = 0, age = 0;
  bit            ack_en = 1'b1;
  int unsigned   n_rise = 0, run = 0, last_run = 0;
  logic          prev_req = 1'b0;

  assign ee.ee_rd_ack  = ack_en && ee.ee_rd_req && (age >= ack_dly);
  assign ee.ee_rd_data = (ee.ee_rd_addr == AW'(CHK_ADDR) && (chk_reads - chk_base) < bad_n)
                         ? ~mem[ee.ee_rd_addr] : mem[ee.ee_rd_addr];

  always @(posedge timer_clk) begin
    age      <= ee.ee_rd_req ? age + 1 : 0;
    prev_req <= ee.ee_rd_req;
    if (ee.ee_rd_req && !prev_req) n_rise <= n_rise + 1;
    if (ee.ee_rd_req) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
    if (ee.ee_rd_req && ee.ee_rd_ack && ee.ee_rd_addr == AW'(CHK_ADDR)) chk_reads <= chk_reads + 1;
  end

  int n_pass = 0, n_chk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: each attempt is settle + (words+1) reads + one CHECK cycle.
  // A read costs the req-high cycles (ack_dly+1) plus one idle cycle.
  function automatic int unsigned ok_len(input int unsigned d);
    return SETTLE_CYC + (CFG_WORDS + 1) * (d + 2) + 1;
  endfunction

  function automatic int unsigned to_len();
    return SETTLE_CYC + 1 + ACK_TO + 1;
  endfunction

  function automatic logic [DW-1:0] good_chk();
    logic [DW-1:0] x = '0;
    for (int i = 0; i < CFG_WORDS; i++) x ^= mem[CFG_BASE + i];
    return x;
  endfunction

  function automatic logic [CW-1:0] image();
    logic [CW-1:0] v;
    for (int i = 0; i < CFG_WORDS; i++) v[i*DW +: DW] = mem[CFG_BASE + i];
    return v;
  endfunction

  task automatic rand_words();
    for (int i = 0; i < CFG_WORDS; i++) mem[CFG_BASE + i] = DW'($urandom);
    mem[CHK_ADDR] = good_chk();
  endtask

  task automatic apply_reset();
    por_rst_n = 1'b0;
    @(posedge timer_clk);
    @(negedge timer_clk);
  endtask

  task automatic release_reset();
    chk_base = chk_reads;
    @(negedge timer_clk);
    por_rst_n = 1'b1;
  endtask

  // Counts posedges until done; flags any cfg_data change while done is low.
  task automatic run_to_done(input int start, input logic [CW-1:0] hold_val,
                             output int cyc, output bit stable);
    cyc    = start;
    stable = 1'b1;
    while (!por_cfg_done && cyc < 3000) begin
      @(posedge timer_clk);
      #1;
      cyc++;
      if (!por_cfg_done && cfg_data !== hold_val) stable = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            cyc, rl;
    bit            stable, quiet, pass, found;
    int unsigned   r0, att;
    logic [CW-1:0] exp_a, exp_b;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    ee.ee_wbusy_comb = 1'b0;
    por_rst_n = 1'b0;
    #12;
    check("rst_req",    ee.ee_rd_req, 0);
    check("rst_addr",   ee.ee_rd_addr, CFG_BASE);
    check("rst_data",   cfg_data, 0);
    check("rst_done",   por_cfg_done, 0);
    check("rst_done_r", por_cfg_done_r, 0);
    check("rst_err",    cfg_err, 0);

    // Nominal image, ack in the first req cycle
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h44; mem[3] = 8'h88; mem[4] = 8'hFF;
    ack_dly = 0; bad_n = 0; r0 = n_rise;
    release_reset();
    run_to_done(0, '0, cyc, stable);
    check("nom_cyc",    cyc, 27);
    check("nom_data",   cfg_data, 32'h88442211);
    check("nom_err",    cfg_err, 0);
    check("nom_stable", stable, 1);
    check("nom_done_r0", por_cfg_done_r, 0);
    @(posedge timer_clk); #1;
    check("nom_done_r1", por_cfg_done_r, 1);
    check("nom_rises",  n_rise - r0, CFG_WORDS + 1);

    // Random images with random ack latency and checksum corruption; a reload during settle is dropped
    for (int k = 0; k < 5; k++) begin
      apply_reset();
      rand_words();
      ack_dly = $urandom_range(0, 2);
      bad_n   = (k == 0) ? 1 : (k == 1) ? 3 : $urandom_range(0, 3);
      r0      = n_rise;
      release_reset();
      rl = $urandom_range(1, 10);
      repeat (rl) @(negedge timer_clk);
      cfg_reload = 1'b1;
      @(negedge timer_clk);
      cfg_reload = 1'b0;
      pass  = (bad_n <= MAX_RETRY);
      att   = pass ? bad_n + 1 : MAX_RETRY + 1;
      exp_a = pass ? image() : '0;
      run_to_done(rl + 1, '0, cyc, stable);
      check("rnd_cyc",    cyc, att * ok_len(ack_dly));
      check("rnd_data",   cfg_data, exp_a);
      check("rnd_err",    cfg_err, !pass);
      check("rnd_stable", stable, 1);
      check("rnd_rises",  n_rise - r0, att * (CFG_WORDS + 1));
    end

    // wbusy high at REQ entry blocks launch; raised mid-request it does not drop req
    apply_reset();
    rand_words();
    ack_dly = 3; bad_n = 0;
    ee.ee_wbusy_comb = 1'b1;
    release_reset();
    quiet = 1'b1;
    for (int c = 1; c <= SETTLE_CYC + 20; c++) begin
      @(posedge timer_clk); #1;
      if (ee.ee_rd_req !== 1'b0) quiet = 1'b0;
    end
    check("wb_quiet", quiet, 1);
    ee.ee_wbusy_comb = 1'b0;
    @(posedge timer_clk); #1;
    check("wb_rise", ee.ee_rd_req, 1);
    ee.ee_wbusy_comb = 1'b1;
    @(posedge timer_clk); #1;
    check("wb_hold1", ee.ee_rd_req, 1);
    @(posedge timer_clk); #1;
    check("wb_hold2", ee.ee_rd_req, 1);
    ee.ee_wbusy_comb = 1'b0;
    run_to_done(SETTLE_CYC + 23, '0, cyc, stable);
    check("wb_cyc",  cyc, ok_len(3) + 20);
    check("wb_data", cfg_data, image());

    // No ack ever: three timed-out attempts, defaults and error flag
    apply_reset();
    ack_en = 1'b0; bad_n = 0; r0 = n_rise;
    release_reset();
    run_to_done(0, '0, cyc, stable);
    check("to_cyc",   cyc, (MAX_RETRY + 1) * to_len());
    check("to_done",  por_cfg_done, 1);
    check("to_data",  cfg_data, 0);
    check("to_err",   cfg_err, 1);
    check("to_rises", n_rise - r0, MAX_RETRY + 1);
    check("to_run",   last_run, ACK_TO);
    ack_en = 1'b1;

    // Reset pulse during word 2, then a reload from DONE with a new image
    apply_reset();
    rand_words();
    ack_dly = 1; bad_n = 0;
    exp_a = image();
    release_reset();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge timer_clk); #1;
      if (ee.ee_rd_req && ee.ee_rd_addr == AW'(CFG_BASE + 2)) found = 1'b1;
    end
    check("mid_found", found, 1);
    #1 por_rst_n = 1'b0;
    #1;
    check("mid_req",    ee.ee_rd_req, 0);
    check("mid_addr",   ee.ee_rd_addr, CFG_BASE);
    check("mid_data",   cfg_data, 0);
    check("mid_done",   por_cfg_done, 0);
    check("mid_done_r", por_cfg_done_r, 0);
    check("mid_err",    cfg_err, 0);
    release_reset();
    run_to_done(0, '0, cyc, stable);
    check("mid_cyc",  cyc, ok_len(1));
    check("mid_img",  cfg_data, exp_a);

    rand_words();
    exp_b = image();
    @(negedge timer_clk);
    cfg_reload = 1'b1;
    @(negedge timer_clk);
    cfg_reload = 1'b0;
    check("rl_done_drop", por_cfg_done, 0);
    check("rl_data_hold", cfg_data, exp_a);
    run_to_done(0, exp_a, cyc, stable);
    check("rl_cyc",    cyc, ok_len(1));
    check("rl_data",   cfg_data, exp_b);
    check("rl_stable", stable, 1);
    check("rl_err",    cfg_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
